// File: rtl/ising_run_sequencer_if.sv
// ising_run_sequencer_if: host weight stream plus matrix weight-write/reset pins.
interface ising_run_sequencer_if;
    logic        w_valid;
    logic [31:0] w_data;
    logic        w_ready;
    logic        ising_rstn;
    logic        wready;
    logic [31:0] wr_addr;
    logic [31:0] wdata;
    modport master (input w_valid, w_data, output w_ready, ising_rstn, wready, wr_addr, wdata);
    modport slave (output w_valid, w_data, input w_ready, ising_rstn, wready, wr_addr, wdata);
endinterface

// File: rtl/ising_run_sequencer.sv
// ising_run_sequencer: loads N*N weights, holds the matrix in reset, anneals, then samples spins.
module ising_run_sequencer #(
    parameter int          N            = 8,
    parameter logic [7:0]  ADDR_TAG     = 8'h01,
    parameter int          RESET_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   axi_rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [31:0]            run_cycles,
    input  logic [N-1:0]           outputs_ver,
    output logic [N-1:0]           result,
    output logic                   result_valid,
    output logic                   busy,
    ising_run_sequencer_if.master  bus
);
    localparam int LN = $clog2(N);
    localparam int KW = $clog2(N * N) + 1;
    typedef enum logic [2:0] {IDLE, LOAD, SETTLE, RUN, SAMPLE, DONE} state_t;
    state_t        state;
    logic [KW-1:0] k;
    logic [31:0]   cnt;
    logic [31:0]   run_len;
    logic [N-1:0]  sync1;
    logic [N-1:0]  sync2;
    logic          hs;
    logic [10:0]   d;
    logic [10:0]   s;
    assign bus.w_ready = state == LOAD;
    assign busy        = state != IDLE;
    assign hs          = bus.w_valid && bus.w_ready;
    assign d           = 11'(k >> LN);
    assign s           = 11'(k & KW'(N - 1));
    always_ff @(posedge clk) begin
        sync1 <= outputs_ver;
        sync2 <= sync1;
        if (axi_rst) begin
            state          <= IDLE;
            k              <= '0;
            cnt            <= '0;
            run_len        <= '0;
            sync1          <= '0;
            sync2          <= '0;
            result         <= '0;
            result_valid   <= 1'b0;
            bus.ising_rstn <= 1'b0;
            bus.wready     <= 1'b0;
            bus.wr_addr    <= '0;
            bus.wdata      <= '0;
        end else if (abort && state != IDLE) begin
            state          <= IDLE;
            result_valid   <= 1'b0;
            bus.ising_rstn <= 1'b0;
            bus.wready     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    result_valid <= 1'b0;
                    if (start) begin
                        state   <= LOAD;
                        k       <= '0;
                        run_len <= run_cycles == '0 ? 32'd1 : run_cycles;
                    end
                end
                LOAD: begin
                    bus.wready <= hs;
                    if (hs) begin
                        bus.wr_addr <= {ADDR_TAG, d, s, 2'b00};
                        bus.wdata   <= bus.w_data;
                        k           <= k + 1'b1;
                        if (k == KW'(N * N - 1)) begin
                            state <= SETTLE;
                            cnt   <= '0;
                        end
                    end
                end
                // cnt==0 marks the final strobe cycle; reset hold is counted after it
                SETTLE: begin
                    bus.wready <= 1'b0;
                    if (cnt == 32'(RESET_CYCLES)) begin
                        state          <= RUN;
                        cnt            <= 32'd1;
                        bus.ising_rstn <= 1'b1;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                RUN: begin
                    if (cnt == run_len) state <= SAMPLE;
                    else cnt <= cnt + 32'd1;
                end
                SAMPLE: begin
                    result         <= sync2;
                    result_valid   <= 1'b1;
                    bus.ising_rstn <= 1'b0;
                    state          <= DONE;
                end
                DONE: begin
                    result_valid <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ising_run_sequencer.sv
// tb_ising_run_sequencer: random + directed runs checked against a schedule-based model every cycle.
module tb_ising_run_sequencer;
    localparam int N  = 4;
    localparam int RC = 16;
    logic          clk = 1'b0;
    logic          axi_rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [31:0]   run_cycles = '0;
    logic [N-1:0]  outputs_ver = '0;
    logic [N-1:0]  result;
    logic          result_valid;
    logic          busy;
    int            checks = 0;
    int            failures = 0;
    ising_run_sequencer_if bus ();
    ising_run_sequencer #(.N(N), .ADDR_TAG(8'h01), .RESET_CYCLES(RC)) dut (
        .clk(clk), .axi_rst(axi_rst), .start(start), .abort(abort), .run_cycles(run_cycles),
        .outputs_ver(outputs_ver), .result(result), .result_valid(result_valid), .busy(busy), .bus(bus)
    );
    always #5 clk = ~clk;
    // model: absolute-cycle schedule derived from the cycle of the last accepted weight
    int           cyc = 0;
    int           nwords = 0;
    int           rb = 0;
    int           re = 0;
    int           dn = 0;
    logic [31:0]  rl = '0;
    bit           active = 0;
    bit           loading = 0;
    logic         e_wready = 0, e_rstn = 0, e_rv = 0;
    logic [31:0]  e_addr = '0, e_wdata = '0;
    logic [N-1:0] e_result = '0;
    logic [N-1:0] hist [4];
    always @(posedge clk) begin
        cyc++;
        hist[cyc % 4] = outputs_ver;
        if (axi_rst) begin
            active = 0; loading = 0; nwords = 0;
            e_wready = 0; e_rstn = 0; e_rv = 0; e_addr = '0; e_wdata = '0; e_result = '0;
        end else begin
            e_wready = 0; e_rv = 0; e_rstn = 0;
            if (active && abort) begin
                active = 0; loading = 0;
            end else if (!active && start) begin
                active = 1; loading = 1; nwords = 0;
                rl = run_cycles == 0 ? 32'd1 : run_cycles;
            end else if (active) begin
                if (loading && bus.w_valid) begin
                    e_wready = 1;
                    e_addr = {8'h01, 11'(nwords / N), 11'(nwords % N), 2'b00};
                    e_wdata = bus.w_data;
                    nwords++;
                    if (nwords == N * N) begin
                        loading = 0;
                        rb = cyc + RC + 1;
                        re = rb + int'(rl);
                        dn = re + 1;
                    end
                end
                if (!loading) begin
                    e_rstn = cyc >= rb && cyc <= re;
                    if (cyc == dn) begin
                        e_rv = 1;
                        e_result = hist[(cyc - 2) % 4];
                    end
                    if (cyc == dn + 1) active = 0;
                end
            end
        end
    end
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
        end
    endtask
    bit directed = 0;
    bit lit_res = 0;
    bit first_after_abort = 0;
    int exp_len = 0;
    int rl_cnt = 0;
    always @(negedge clk) begin
        chk("w_ready", 32'(bus.w_ready), 32'(loading));
        chk("busy", 32'(busy), 32'(active));
        chk("wready", 32'(bus.wready), 32'(e_wready));
        chk("wr_addr", bus.wr_addr, e_addr);
        chk("wdata", bus.wdata, e_wdata);
        chk("ising_rstn", 32'(bus.ising_rstn), 32'(e_rstn));
        chk("result", 32'(result), 32'(e_result));
        chk("result_valid", 32'(result_valid), 32'(e_rv));
        if (directed && bus.wready && bus.wdata == 32'd6) chk("word6_addr", bus.wr_addr, 32'h01002008);
        if (directed && bus.wready && bus.wdata == 32'd15) chk("word15_addr", bus.wr_addr, 32'h0100600C);
        if (lit_res && result_valid) chk("result_lit", 32'(result), 32'h0000000A);
        if (first_after_abort && bus.wready) begin
            chk("reload_addr0", bus.wr_addr, 32'h01000000);
            first_after_abort = 0;
        end
        if (bus.ising_rstn) rl_cnt++;
        else if (rl_cnt > 0) begin
            if (exp_len != 0) chk("rstn_len", 32'(rl_cnt), 32'(exp_len));
            rl_cnt = 0;
        end
    end
    bit ov_rand = 0;
    task automatic tick();
        @(posedge clk);
        #1;
        if (ov_rand) outputs_ver = N'($urandom);
    endtask
    task automatic run_seq(input logic [31:0] rc, input int vmode, input int abort_k,
                           input int abort_run, input int rst_run, input bit dstart);
        int  i = 0;
        int  n = 0;
        bit  hs;
        start = 1; run_cycles = rc;
        tick();
        start = 0; run_cycles = $urandom;
        while (i < N * N && n < 2000) begin
            if (i == abort_k) begin
                bus.w_valid = 0; start = 1; abort = 1;
                tick();
                abort = 0; start = 0;
                return;
            end
            bus.w_valid = vmode == 0 ? 1'b1 : vmode == 1 ? n[0] : 1'($urandom_range(0, 1));
            bus.w_data = directed ? 32'(i) : $urandom;
            start = dstart ? 1'($urandom_range(0, 1)) : 1'b0;
            hs = bus.w_valid && bus.w_ready;
            tick();
            if (hs) i++;
            n++;
        end
        bus.w_valid = 0; start = 0;
        if (abort_run > 0 || rst_run > 0) begin
            n = 0;
            while (!bus.ising_rstn && n < 500) begin tick(); n++; end
            repeat (abort_run > 0 ? abort_run : rst_run) tick();
            if (abort_run > 0) abort = 1; else axi_rst = 1;
            tick();
            abort = 0; axi_rst = 0;
            return;
        end
        n = 0;
        while (busy && n < 10000) begin
            start = dstart ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            n++;
        end
        start = 0;
        if (n >= 10000) begin
            checks++; failures++;
            $display("FAIL timeout t=%0t actual=busy required=idle", $time);
        end
        tick();
    endtask
    initial begin
        bus.w_valid = 0; bus.w_data = '0;
        repeat (3) tick();
        axi_rst = 0;
        tick();
        directed = 1; lit_res = 1; exp_len = 6; outputs_ver = 4'b1010;
        run_seq(32'd5, 0, -1, 0, 0, 0);
        run_seq(32'd5, 1, -1, 0, 0, 1);
        lit_res = 0; exp_len = 2;
        run_seq(32'd0, 0, -1, 0, 0, 0);
        exp_len = 0; ov_rand = 1;
        run_seq(32'd3, 0, 7, 0, 0, 0);
        tick();
        first_after_abort = 1;
        run_seq(32'd10, 0, -1, 3, 0, 0);
        tick();
        run_seq(32'd10, 0, -1, 0, 4, 0);
        tick();
        directed = 0;
        for (int r = 0; r < 10; r++) begin
            int ak = $urandom_range(0, 5) == 0 ? int'($urandom_range(0, N * N - 1)) : -1;
            int ar = $urandom_range(0, 5) == 0 ? int'($urandom_range(1, 4)) : 0;
            run_seq(32'($urandom_range(0, 20)), 2, ak, ar, 0, 1);
            repeat ($urandom_range(0, 3)) tick();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ising_run_sequencer.md
Name: ising_run_sequencer

Overview:
Run controller for the oscillator core matrix. On a start command it streams N*N coupling weights from a host valid/ready stream into the matrix weight-write port and holds the array in reset while loading. It then releases the array, lets it anneal for a programmable number of cycles, and samples and synchronizes the vertical oscillator outputs into a result word. Sits between the AXI-side host logic and the core matrix, and is the only driver of its ising_rstn/wready/wr_addr/wdata pins.

Parameters:
N, 8, matrix dimension; power of two, 2..2048
ADDR_TAG, 8'h01, value driven on wr_addr[31:24]; equals the weight address tag define
RESET_CYCLES, 16, cycles ising_rstn stays low after the last weight write, >=1

Ports:
clk  in  1  system clock
axi_rst  in  1  synchronous active-high reset
start  in  1  begin load+run; sampled only in IDLE
abort  in  1  return to IDLE from any state
run_cycles  in  32  anneal length; latched on accepted start
w_valid  in  1  host weight word valid
w_data  in  32  host weight word
w_ready  out  1  weight word accepted when w_valid&w_ready
ising_rstn  out  1  matrix oscillator reset, active-low
wready  out  1  matrix write strobe
wr_addr  out  32  matrix write address
wdata  out  32  matrix write data
outputs_ver  in  N  asynchronous oscillator outputs from the matrix
result  out  N  synchronized sampled spins
result_valid  out  1  one-cycle pulse when result updates
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (axi_rst=1 at a clk edge): state=IDLE, ising_rstn=0, wready=0, wr_addr=0, wdata=0, w_ready=0, result=0, result_valid=0, counters=0. Reset mid-operation aborts immediately, with no result_valid.
- States: IDLE, LOAD, SETTLE, RUN, SAMPLE, DONE. ising_rstn=1 only in RUN and SAMPLE.
- IDLE: start=1 -> LOAD. Latch run_cycles; a value of 0 is treated as 1. Clear word counter k.
- LOAD: w_ready=1 combinationally. On a handshake, the next cycle drives wready=1, wdata=w_data, and wr_addr={ADDR_TAG, d[10:0], s[10:0], 2'b00} with d=k/N and s=k%N (row-major: s inner, d outer); k increments.
  - No handshake: wready=0 next cycle; k holds. wr_addr/wdata hold their last value.
  - Handshake with k=N*N-1 -> SETTLE. The last write strobe occurs in the first SETTLE cycle.
- SETTLE: w_ready=0, ising_rstn=0. Counts RESET_CYCLES cycles starting with the cycle after the final write strobe, then -> RUN.
- RUN: ising_rstn=1 for exactly run_cycles cycles, then -> SAMPLE.
- Synchronizer: a 2-flop synchronizer on outputs_ver runs continuously.
- SAMPLE: one cycle. result<=second sync stage, then -> DONE.
- DONE: one cycle. result_valid=1, ising_rstn=0, -> IDLE. result holds until the next SAMPLE.
- abort=1 in any non-IDLE state: next state IDLE, ising_rstn=0, wready=0, no result_valid, result unchanged. abort takes priority over all other transitions. start during abort is ignored.
- start while busy: ignored. run_cycles changes while busy: ignored.
- w_valid outside LOAD: not accepted (w_ready=0).
- Counters: k is $clog2(N*N)+1 bits wide. The run counter is 32 bits and must not wrap, up to 2^32-1.

Test Plan:
- N=4, reset, start, 16 back-to-back words w_data=k -> 16 consecutive wready pulses. Word 6 has wr_addr=0x01002008 and wdata=6. Word 15 has wr_addr=0x0100600C. ising_rstn=0 throughout.
- Same load with w_valid toggling every other cycle -> still exactly 16 write strobes, addresses in row-major order, none duplicated or skipped.
- run_cycles=5, RESET_CYCLES=16, outputs_ver=4'b1010 static -> ising_rstn high for exactly 6 cycles (5 RUN + 1 SAMPLE), beginning 16 cycles after the last strobe. result=4'b1010 with a single result_valid pulse; busy low the next cycle.
- run_cycles=0 -> behaves as run_cycles=1 (1 RUN cycle).
- abort asserted during LOAD at k=7, then during RUN -> IDLE next cycle, ising_rstn=0, no result_valid, previous result retained. A subsequent start reloads from k=0 (first wr_addr=0x01000000).
- axi_rst asserted mid-RUN -> all outputs return to their reset values next cycle. start asserted while busy has no effect on the sequence.
